// File: rtl/multi_port_fetch.sv
// multi_port_fetch: two-stage, multi-lane instruction fetch for the GPGPU front end.
// Each lane reads its own replica of the instruction store. Results reach the ID
// stage two cycles after issue. A stall holds the whole pipeline, and a flush clears
// the warp IDs of the selected warps. Fetch_Count counts valid lane deliveries.
module multi_port_fetch #(
    parameter int NUM_PORTS = 2,
    parameter int NUM_WARPS = 8,
    parameter int MASK_W    = 8,
    parameter int ADDR      = 10,
    parameter int DATA      = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           Init_We,
    input  logic [ADDR-1:0]                Init_Addr,
    input  logic [DATA-1:0]                Init_Data,
    output logic [DATA-1:0]                Init_Rdata,
    input  logic                           Init_Done,
    input  logic [NUM_PORTS*32-1:0]        Issue_PC,
    input  logic [NUM_PORTS*32-1:0]        Issue_PC_Plus4,
    input  logic [NUM_PORTS*MASK_W-1:0]    Issue_Mask,
    input  logic [NUM_PORTS*NUM_WARPS-1:0] Issue_WarpID,
    input  logic                           Stall,
    input  logic                           Flush_IF,
    input  logic [NUM_WARPS-1:0]           Flush_Warp,
    input  logic                           Count_Clr,
    output logic [NUM_PORTS*DATA-1:0]      ID_Instr,
    output logic [NUM_PORTS*MASK_W-1:0]    ID_Mask,
    output logic [NUM_PORTS*NUM_WARPS-1:0] ID_WarpID,
    output logic [NUM_PORTS*32-1:0]        ID_PC_Plus4,
    output logic [31:0]                    Fetch_Count
);

    localparam int DEPTH = 1 << ADDR;

    // One replica per lane, so every lane has a private read port.
    logic [DATA-1:0] store_mem [NUM_PORTS][DEPTH];

    logic [NUM_PORTS-1:0][ADDR-1:0]      s1_addr_q,  s1_addr_d;
    logic [NUM_PORTS-1:0][NUM_WARPS-1:0] s1_warp_q,  s1_warp_d;
    logic [NUM_PORTS-1:0][MASK_W-1:0]    s1_mask_q,  s1_mask_d;
    logic [NUM_PORTS-1:0][31:0]          s1_pc4_q,   s1_pc4_d;
    logic [NUM_PORTS-1:0][DATA-1:0]      s2_instr_q, s2_instr_d;
    logic [NUM_PORTS-1:0][NUM_WARPS-1:0] s2_warp_q,  s2_warp_d;
    logic [NUM_PORTS-1:0][MASK_W-1:0]    s2_mask_q,  s2_mask_d;
    logic [NUM_PORTS-1:0][31:0]          s2_pc4_q,   s2_pc4_d;
    logic [31:0]                         fetch_count_q, fetch_count_d;
    logic [31:0]                         fetch_inc;
    logic [DATA-1:0]                     init_rdata_q, init_rdata_d;

    // PC bits outside the word address are intentionally ignored (addresses wrap).
    logic unused_pc_bits;
    assign unused_pc_bits = ^Issue_PC;

    // Store write port: every replica is written so the lanes stay identical.
    always_ff @(posedge clk) begin
        if (Init_We) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                store_mem[i][Init_Addr] <= Init_Data;
            end
        end
    end

    // Next-state for both pipeline stages of every lane, including stall hold and flush.
    always_comb begin
        s1_addr_d  = s1_addr_q;
        s1_warp_d  = s1_warp_q;
        s1_mask_d  = s1_mask_q;
        s1_pc4_d   = s1_pc4_q;
        s2_instr_d = s2_instr_q;
        s2_warp_d  = s2_warp_q;
        s2_mask_d  = s2_mask_q;
        s2_pc4_d   = s2_pc4_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!Stall) begin
                s1_addr_d[i]  = Issue_PC[i*32+2 +: ADDR];
                s1_warp_d[i]  = Init_Done ? Issue_WarpID[i*NUM_WARPS +: NUM_WARPS] : '0;
                s1_mask_d[i]  = Issue_Mask[i*MASK_W +: MASK_W];
                s1_pc4_d[i]   = Issue_PC_Plus4[i*32 +: 32];
                // Store read happens here. A same-edge write is only visible next time.
                s2_instr_d[i] = store_mem[i][s1_addr_q[i]];
                s2_warp_d[i]  = Flush_IF ? (s1_warp_q[i] & ~Flush_Warp) : s1_warp_q[i];
                s2_mask_d[i]  = s1_mask_q[i];
                s2_pc4_d[i]   = s1_pc4_q[i];
            end else if (Flush_IF) begin
                // Held entries keep their data; only the flushed warps lose validity.
                s1_warp_d[i] = s1_warp_q[i] & ~Flush_Warp;
                s2_warp_d[i] = s2_warp_q[i] & ~Flush_Warp;
            end
        end
    end

    // Delivery counter: counts lanes that load a valid entry into the output stage.
    always_comb begin
        fetch_inc = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!Stall && (s2_warp_d[i] != '0)) begin
                fetch_inc = fetch_inc + 32'd1;
            end
        end
        fetch_count_d = Count_Clr ? 32'd0 : (fetch_count_q + fetch_inc);
    end

    // Readback always comes from replica 0.
    always_comb begin
        init_rdata_d = store_mem[0][Init_Addr];
    end

    // Pipeline, counter and readback registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_addr_q     <= '0;
            s1_warp_q     <= '0;
            s1_mask_q     <= '0;
            s1_pc4_q      <= '0;
            s2_instr_q    <= '0;
            s2_warp_q     <= '0;
            s2_mask_q     <= '0;
            s2_pc4_q      <= '0;
            fetch_count_q <= '0;
            init_rdata_q  <= '0;
        end else begin
            s1_addr_q     <= s1_addr_d;
            s1_warp_q     <= s1_warp_d;
            s1_mask_q     <= s1_mask_d;
            s1_pc4_q      <= s1_pc4_d;
            s2_instr_q    <= s2_instr_d;
            s2_warp_q     <= s2_warp_d;
            s2_mask_q     <= s2_mask_d;
            s2_pc4_q      <= s2_pc4_d;
            fetch_count_q <= fetch_count_d;
            init_rdata_q  <= init_rdata_d;
        end
    end

    assign ID_Instr    = s2_instr_q;
    assign ID_Mask     = s2_mask_q;
    assign ID_WarpID   = s2_warp_q;
    assign ID_PC_Plus4 = s2_pc4_q;
    assign Fetch_Count = fetch_count_q;
    assign Init_Rdata  = init_rdata_q;

endmodule

// File: tb/tb_multi_port_fetch.sv
// Bench for multi_port_fetch. It uses a per-lane scoreboard of expected deliveries.
// Each entry is tagged with the pipeline-advance count at which it must appear.
module tb_multi_port_fetch;

    localparam int NP = 2;
    localparam int NW = 8;
    localparam int MW = 8;
    localparam int AW = 10;
    localparam int DW = 32;

    logic              clk;
    logic              rst_n;
    logic              Init_We;
    logic [AW-1:0]     Init_Addr;
    logic [DW-1:0]     Init_Data;
    logic [DW-1:0]     Init_Rdata;
    logic              Init_Done;
    logic [NP*32-1:0]  Issue_PC;
    logic [NP*32-1:0]  Issue_PC_Plus4;
    logic [NP*MW-1:0]  Issue_Mask;
    logic [NP*NW-1:0]  Issue_WarpID;
    logic              Stall;
    logic              Flush_IF;
    logic [NW-1:0]     Flush_Warp;
    logic              Count_Clr;
    logic [NP*DW-1:0]  ID_Instr;
    logic [NP*MW-1:0]  ID_Mask;
    logic [NP*NW-1:0]  ID_WarpID;
    logic [NP*32-1:0]  ID_PC_Plus4;
    logic [31:0]       Fetch_Count;

    multi_port_fetch #(
        .NUM_PORTS(NP), .NUM_WARPS(NW), .MASK_W(MW), .ADDR(AW), .DATA(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .Init_We(Init_We), .Init_Addr(Init_Addr), .Init_Data(Init_Data),
        .Init_Rdata(Init_Rdata), .Init_Done(Init_Done),
        .Issue_PC(Issue_PC), .Issue_PC_Plus4(Issue_PC_Plus4),
        .Issue_Mask(Issue_Mask), .Issue_WarpID(Issue_WarpID),
        .Stall(Stall), .Flush_IF(Flush_IF), .Flush_Warp(Flush_Warp),
        .Count_Clr(Count_Clr),
        .ID_Instr(ID_Instr), .ID_Mask(ID_Mask), .ID_WarpID(ID_WarpID),
        .ID_PC_Plus4(ID_PC_Plus4), .Fetch_Count(Fetch_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  warp;
        logic [7:0]  mask;
        logic [31:0] pc4;
        int          due;
    } ent_t;

    ent_t        sbq [NP][$];
    ent_t        hold_exp [NP];
    ent_t        zero_ent;
    logic [31:0] img [1024];
    logic [31:0] exp_cnt;
    int          adv;
    int          n_checks;
    int          n_fail;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle();
        Issue_PC       = '0;
        Issue_PC_Plus4 = '0;
        Issue_Mask     = '0;
        Issue_WarpID   = '0;
        Stall          = 1'b0;
        Flush_IF       = 1'b0;
        Flush_Warp     = '0;
        Count_Clr      = 1'b0;
        Init_We        = 1'b0;
    endtask

    // Drive one lane for the coming edge and record what it should deliver.
    task automatic set_lane(input int l, input logic [31:0] pc, input logic [7:0] warp,
                            input logic [7:0] mask);
        ent_t e;
        Issue_PC[l*32 +: 32]       = pc;
        Issue_PC_Plus4[l*32 +: 32] = pc + 32'd4;
        Issue_Mask[l*MW +: MW]     = mask;
        Issue_WarpID[l*NW +: NW]   = warp;
        if (warp != 8'h00 && Init_Done && !Stall) begin
            e.instr = img[pc[11:2]];
            e.warp  = warp;
            e.mask  = mask;
            e.pc4   = pc + 32'd4;
            e.due   = adv + 2;
            sbq[l].push_back(e);
        end
    endtask

    // Compare outputs after an edge against the scoreboard.
    task automatic monitor(input logic advanced);
        ent_t        e;
        logic [7:0]  w;
        logic [31:0] ins;
        for (int l = 0; l < NP; l++) begin
            w   = ID_WarpID[l*NW +: NW];
            ins = ID_Instr[l*DW +: DW];
            if (advanced) begin
                if (w != 8'h00) begin
                    while (sbq[l].size() > 0 && sbq[l][0].warp == 8'h00) void'(sbq[l].pop_front());
                    if (sbq[l].size() == 0) begin
                        check_val($sformatf("lane%0d_extra", l), 64'(w), 64'h0);
                        hold_exp[l] = zero_ent;
                    end else begin
                        e = sbq[l].pop_front();
                        check_val($sformatf("lane%0d_warp", l), 64'(w), 64'(e.warp));
                        check_val($sformatf("lane%0d_instr", l), 64'(ins), 64'(e.instr));
                        check_val($sformatf("lane%0d_mask", l), 64'(ID_Mask[l*MW +: MW]), 64'(e.mask));
                        check_val($sformatf("lane%0d_pc4", l), 64'(ID_PC_Plus4[l*32 +: 32]), 64'(e.pc4));
                        check_val($sformatf("lane%0d_latency", l), 64'(adv), 64'(e.due));
                        hold_exp[l] = e;
                    end
                end else begin
                    while (sbq[l].size() > 0 && sbq[l][0].warp == 8'h00 && sbq[l][0].due <= adv)
                        void'(sbq[l].pop_front());
                    if (sbq[l].size() > 0 && sbq[l][0].due <= adv) begin
                        e = sbq[l].pop_front();
                        check_val($sformatf("lane%0d_missing", l), 64'h0, 64'(e.warp));
                    end
                    hold_exp[l] = zero_ent;
                end
            end else begin
                check_val($sformatf("lane%0d_stall_warp", l), 64'(w), 64'(hold_exp[l].warp));
                if (hold_exp[l].warp != 8'h00)
                    check_val($sformatf("lane%0d_stall_instr", l), 64'(ins), 64'(hold_exp[l].instr));
            end
        end
        check_val("fetch_count", 64'(Fetch_Count), 64'(exp_cnt));
    endtask

    // Apply flush/count expectations for the coming edge, clock it, then check.
    task automatic tick();
        logic        stl;
        logic [31:0] inc;
        ent_t        e;
        stl = Stall;
        inc = 32'd0;
        for (int l = 0; l < NP; l++) begin
            for (int k = 0; k < sbq[l].size(); k++) begin
                if (sbq[l][k].due == adv + 1) begin
                    e = sbq[l][k];
                    if (Flush_IF) e.warp = e.warp & ~Flush_Warp;
                    sbq[l][k] = e;
                    if (!stl && e.warp != 8'h00) inc = inc + 32'd1;
                end
            end
            if (Flush_IF && stl) hold_exp[l].warp = hold_exp[l].warp & ~Flush_Warp;
        end
        if (Count_Clr) exp_cnt = 32'd0;
        else           exp_cnt = exp_cnt + inc;
        @(posedge clk);
        if (!stl) adv++;
        @(negedge clk);
        monitor(!stl);
    endtask

    task automatic write_word(input logic [9:0] a, input logic [31:0] d);
        Init_We   = 1'b1;
        Init_Addr = a;
        Init_Data = d;
        img[a]    = d;
        tick();
        Init_We   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_warp"},  64'(ID_WarpID),   64'h0);
        check_val({tag, "_instr"}, ID_Instr,         64'h0);
        check_val({tag, "_mask"},  64'(ID_Mask),     64'h0);
        check_val({tag, "_pc4"},   ID_PC_Plus4,      64'h0);
        check_val({tag, "_count"}, 64'(Fetch_Count), 64'h0);
        check_val({tag, "_rdata"}, 64'(Init_Rdata),  64'h0);
    endtask

    int pending;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        adv       = 0;
        exp_cnt   = 32'd0;
        zero_ent  = '{32'h0, 8'h0, 8'h0, 32'h0, 0};
        hold_exp  = '{zero_ent, zero_ent};
        rst_n     = 1'b0;
        Init_Done = 1'b0;
        Init_Addr = '0;
        Init_Data = '0;
        idle();
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Preload and readback.
        for (int i = 0; i < 16; i++) write_word(10'(i), 32'hA000_0000 + 32'(i) * 32'h111);
        write_word(10'd5, 32'hDEADBEEF);
        write_word(10'd6, 32'h12345678);
        Init_Addr = 10'd5;
        tick();
        check_val("init_rdata5", 64'(Init_Rdata), 64'hDEADBEEF);
        Init_Addr = 10'd6;
        tick();
        check_val("init_rdata6", 64'(Init_Rdata), 64'h12345678);

        // Issue gate: nothing delivered while Init_Done is low.
        set_lane(0, 32'h8, 8'h01, 8'h33);
        set_lane(1, 32'hC, 8'h02, 8'h44);
        tick();
        idle();
        repeat (2) tick();
        check_val("gate_warp", 64'(ID_WarpID), 64'h0);
        Init_Done = 1'b1;

        // Basic two-lane fetch with two-cycle latency.
        set_lane(0, 32'h14, 8'h01, 8'hFF);
        set_lane(1, 32'h18, 8'h04, 8'h0F);
        tick();
        idle();
        check_val("basic_not_early", 64'(ID_WarpID), 64'h0);
        tick();
        check_val("basic_instr", ID_Instr, {32'h12345678, 32'hDEADBEEF});
        check_val("basic_warp", 64'(ID_WarpID), 64'h0401);
        check_val("basic_mask", 64'(ID_Mask), 64'h0FFF);
        check_val("basic_count", 64'(Fetch_Count), 64'd2);

        // Back-to-back issue then a 3-cycle stall.
        for (int c = 0; c < 4; c++) begin
            set_lane(0, 32'h20 + 32'(c) * 4, 8'(1 << c), 8'h10 + 8'(c));
            set_lane(1, 32'h30 + 32'(c) * 4, 8'(8'h80 >> c), 8'hF0 - 8'(c));
            tick();
        end
        idle();
        Stall = 1'b1;
        repeat (3) tick();
        Stall = 1'b0;
        repeat (3) tick();

        // Flush of an in-flight warp, then a non-matching flush.
        set_lane(0, 32'h28, 8'h02, 8'h5A);
        tick();
        idle();
        Flush_IF = 1'b1;
        Flush_Warp = 8'h02;
        tick();
        idle();
        check_val("flush_hit_warp", 64'(ID_WarpID), 64'h0);
        tick();
        set_lane(0, 32'h28, 8'h02, 8'h5A);
        tick();
        idle();
        Flush_IF = 1'b1;
        Flush_Warp = 8'h08;
        tick();
        idle();
        check_val("flush_miss_warp", 64'(ID_WarpID), 64'h02);
        tick();

        // Flush during a stall with entries in both stages.
        set_lane(0, 32'h00, 8'h01, 8'hA1);
        set_lane(1, 32'h04, 8'h02, 8'hA2);
        tick();
        set_lane(0, 32'h08, 8'h04, 8'hB1);
        set_lane(1, 32'h0C, 8'h01, 8'hB2);
        tick();
        idle();
        Stall = 1'b1;
        tick();
        Flush_IF = 1'b1;
        Flush_Warp = 8'h01;
        tick();
        Flush_IF = 1'b0;
        Flush_Warp = 8'h00;
        check_val("stall_flush_warp", 64'(ID_WarpID), 64'h0200);
        tick();
        Stall = 1'b0;
        tick();
        check_val("stall_flush_release", 64'(ID_WarpID), 64'h0004);
        tick();

        // Address wrap, and a fetch right behind a store write.
        set_lane(0, 32'h1004, 8'h10, 8'h01);
        tick();
        idle();
        tick();
        check_val("pc_wrap_instr", 64'(ID_Instr[31:0]), 64'(img[1]));
        write_word(10'd7, 32'hCAFEF00D);
        set_lane(1, 32'h1C, 8'h20, 8'h02);
        tick();
        idle();
        tick();
        check_val("write_then_fetch", 64'(ID_Instr[63:32]), 64'hCAFEF00D);

        // Count clear on the same edge as a valid delivery.
        set_lane(0, 32'h10, 8'h40, 8'h03);
        set_lane(1, 32'h14, 8'h80, 8'h04);
        tick();
        idle();
        Count_Clr = 1'b1;
        tick();
        Count_Clr = 1'b0;
        check_val("count_clr", 64'(Fetch_Count), 64'h0);

        // Counter wrap from a preset value.
        #2;
        force dut.fetch_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.fetch_count_q;
        exp_cnt = 32'hFFFF_FFFE;
        set_lane(0, 32'h18, 8'h01, 8'h05);
        set_lane(1, 32'h1C, 8'h02, 8'h06);
        tick();
        idle();
        tick();
        check_val("count_wrap", 64'(Fetch_Count), 64'h0);

        // Asynchronous reset with entries in flight.
        Init_Addr = 10'd5;
        set_lane(0, 32'h20, 8'h04, 8'h07);
        set_lane(1, 32'h24, 8'h08, 8'h08);
        tick();
        set_lane(0, 32'h28, 8'h10, 8'h09);
        set_lane(1, 32'h2C, 8'h20, 8'h0A);
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        for (int l = 0; l < NP; l++) begin
            sbq[l].delete();
            hold_exp[l] = zero_ent;
        end
        exp_cnt = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();

        for (int l = 0; l < NP; l++) begin
            pending = 0;
            foreach (sbq[l][k]) if (sbq[l][k].warp != 8'h00) pending++;
            check_val($sformatf("lane%0d_drain", l), 64'(pending), 64'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
